// File: rtl/mp_no_cache_mem_pkg.sv
// mp_no_cache_mem_pkg: shared constants, request kinds and width helpers for the cacheless memory model.
package mp_no_cache_mem_pkg;
  localparam int CPU_ADDR_BITS = 32;
  localparam int MEM_DATA_BITS = 128;
  typedef enum logic [1:0] {REQ_IDLE, REQ_READ, REQ_WRITE} req_kind_e;
  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mp_no_cache_mem_rr_arbiter.sv
// mp_no_cache_mem_rr_arbiter: round-robin grant over N requesters with a rotating priority pointer.
module mp_no_cache_mem_rr_arbiter
  import mp_no_cache_mem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           req,
  input  logic                   advance,
  output logic [N-1:0]           gnt,
  output logic [idx_bits(N)-1:0] idx
);
  localparam int IW = idx_bits(N);
  logic [IW-1:0] ptr;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr <= '0;
    else if (advance) ptr <= IW'((int'(idx) + 1) % N);
  end
endmodule

// File: rtl/mp_no_cache_mem.sv
// mp_no_cache_mem: multi-channel cacheless backing memory; round-robin shared 1W1R line array,
// byte-masked read-modify-write, fixed-latency read responses routed back to the issuing channel.
module mp_no_cache_mem
  import mp_no_cache_mem_pkg::*;
#(
  parameter int CPU_WIDTH      = 32,
  parameter int MEM_WIDTH      = MEM_DATA_BITS,
  parameter int DEPTH          = 2 * 1024 * 1024,
  parameter int NCH            = 2,
  parameter int LATENCY        = 1,
  parameter int WORD_ADDR_BITS = CPU_ADDR_BITS - $clog2(CPU_WIDTH / 8)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NCH-1:0]                      cpu_req_valid,
  output logic [NCH-1:0]                      cpu_req_ready,
  input  logic [NCH*WORD_ADDR_BITS-1:0]       cpu_req_addr,
  input  logic [NCH*CPU_WIDTH-1:0]            cpu_req_data,
  input  logic [NCH*(CPU_WIDTH/8)-1:0]        cpu_req_write,
  output logic [NCH-1:0]                      cpu_resp_valid,
  output logic [NCH*CPU_WIDTH-1:0]            cpu_resp_data
);
  localparam int BPW   = CPU_WIDTH / 8;
  localparam int WORDS = MEM_WIDTH / CPU_WIDTH;
  localparam int LW    = $clog2(WORDS);
  localparam int LWW   = idx_bits(WORDS);
  localparam int DW    = $clog2(DEPTH);
  localparam int IW    = idx_bits(NCH);

  logic [IW-1:0]             gid;
  logic                      fire;
  logic                      rd_fire;
  req_kind_e                 kind;
  logic [WORD_ADDR_BITS-1:0] sel_addr;
  logic [CPU_WIDTH-1:0]      sel_data;
  logic [BPW-1:0]            sel_we;
  logic [LWW-1:0]            lower;
  logic [DW-1:0]             line;
  logic [MEM_WIDTH-1:0]      mem [DEPTH];
  logic [MEM_WIDTH-1:0]      cur;
  logic [MEM_WIDTH-1:0]      merged;
  logic [CPU_WIDTH-1:0]      rd_word;
  logic                      tail_v;
  logic [IW-1:0]             tail_id;
  logic [CPU_WIDTH-1:0]      tail_d;

  mp_no_cache_mem_rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (cpu_req_valid),
    .advance (fire),
    .gnt     (cpu_req_ready),
    .idx     (gid)
  );

  assign fire     = |(cpu_req_valid & cpu_req_ready);
  assign sel_addr = cpu_req_addr[gid*WORD_ADDR_BITS +: WORD_ADDR_BITS];
  assign sel_data = cpu_req_data[gid*CPU_WIDTH +: CPU_WIDTH];
  assign sel_we   = cpu_req_write[gid*BPW +: BPW];
  // High address bits beyond the array simply fall off, so addresses alias.
  assign lower    = LWW'(sel_addr & WORD_ADDR_BITS'(WORDS - 1));
  assign line     = DW'(sel_addr >> LW);
  assign cur      = mem[line];
  assign rd_word  = cur[lower*CPU_WIDTH +: CPU_WIDTH];
  assign kind     = !fire ? REQ_IDLE : (|sel_we ? REQ_WRITE : REQ_READ);
  assign rd_fire  = kind == REQ_READ;

  always_comb begin
    merged = cur;
    for (int b = 0; b < BPW; b++)
      if (sel_we[b]) merged[lower*CPU_WIDTH + b*8 +: 8] = sel_data[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (kind == REQ_WRITE) mem[line] <= merged;
  end

  // The output registers form the final stage; only LATENCY-1 stages precede them.
  if (LATENCY == 1) begin : g_l1
    assign tail_v  = rd_fire;
    assign tail_id = gid;
    assign tail_d  = rd_word;
  end else begin : g_ln
    logic [LATENCY-2:0]   pv;
    logic [IW-1:0]        pid [LATENCY-1];
    logic [CPU_WIDTH-1:0] pd  [LATENCY-1];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pv <= '0;
      else pv <= (LATENCY-1)'({pv, rd_fire});
    end
    always_ff @(posedge clk) begin
      pid[0] <= gid;
      pd[0]  <= rd_word;
      for (int i = 1; i < LATENCY - 1; i++) begin
        pid[i] <= pid[i-1];
        pd[i]  <= pd[i-1];
      end
    end
    assign tail_v  = pv[LATENCY-2];
    assign tail_id = pid[LATENCY-2];
    assign tail_d  = pd[LATENCY-2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_resp_valid <= '0;
      cpu_resp_data  <= '0;
    end else begin
      cpu_resp_valid <= NCH'(tail_v) << tail_id;
      if (tail_v) cpu_resp_data[tail_id*CPU_WIDTH +: CPU_WIDTH] <= tail_d;
    end
  end
endmodule
